layer_compositor: RTL and testbench
===================================

Name: layer_compositor

Overview:
- Parametrised, pipelined successor to the fixed five-layer RGB priority mux in the VGA output path.
- Selects the highest-priority visible layer from NUM_LAYERS sprite/tile layers. Layer 0 has the highest priority; a background colour applies when no layer is visible.
- Supports per-layer enable masking and an optional transparency colour key.
- Adds a frame-synchronous effects stage: hit flash, fade-to-black and fade-in, used for game-over and restart transitions.

Parameters:
- NUM_LAYERS, 5: number of input layers; index 0 has the highest priority.
- COLOR_W, 12: pixel width, 4 bits per R/G/B channel. Must be 12.
- KEY_EN, 1: when 1, a layer pixel equal to KEY_RGB is treated as transparent.
- KEY_RGB, 12'hF0F: transparency key colour.
- FLASH_RGB, 12'hFFF: colour forced during a flash.
- FLASH_FRAMES, 4: flash duration in frame_tick pulses (1..255).
- FADE_DIV, 2: frame_tick pulses per fade step (1..255).

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- vid_on  in  1  visible-area flag for the current pixel
- layer_on  in  NUM_LAYERS  per-layer pixel-present flags
- layer_rgb  in  NUM_LAYERS*COLOR_W  layer i colour at bits [COLOR_W*i +: COLOR_W]
- layer_en  in  NUM_LAYERS  per-layer enable mask
- bg_rgb  in  COLOR_W  colour used when no layer is visible
- frame_tick  in  1  one-cycle pulse per frame
- flash_req  in  1  one-cycle pulse, starts a flash
- fade_out_req  in  1  one-cycle pulse, starts fade to black
- fade_in_req  in  1  one-cycle pulse, starts fade back to full brightness
- rgb  out  COLOR_W  composited, effect-applied pixel
- rgb_vid_on  out  1  vid_on delayed to align with rgb
- layer_sel  out  $clog2(NUM_LAYERS+1)  winning layer index; NUM_LAYERS means background or blank
- fx_busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values (asynchronous, active-high):
  - rgb=0, rgb_vid_on=0, layer_sel=NUM_LAYERS, fx_busy=0.
  - FSM=IDLE, level=15, frame and step counters=0.
- Latency: fixed at 2 clk from vid_on/layer inputs to rgb/rgb_vid_on. layer_sel has the same 2-clk latency. There are no stalls.
- Stage 1 (registered):
  - Layer i is visible when layer_on[i] & layer_en[i] & !(KEY_EN & layer_rgb[i]==KEY_RGB).
  - The winner is the lowest visible index; its colour and index are registered.
  - If no layer is visible: colour=bg_rgb, index=NUM_LAYERS.
  - If vid_on=0: colour=0, index=NUM_LAYERS.
- Stage 2 (registered):
  - FLASH state and stage-1 vid_on=1: rgb=FLASH_RGB.
  - Otherwise each 4-bit channel c becomes c-(15-level), saturating at 0. level=15 is identity; level=0 is black.
  - vid_on=0 always gives rgb=0.
- Effects FSM:
  - IDLE:
    - flash_req -> FLASH, frame counter cleared.
    - else fade_out_req -> FADE_OUT, step counter cleared.
    - fade_in_req is ignored in IDLE.
  - FLASH: each frame_tick increments the counter. On the FLASH_FRAMES-th tick -> IDLE. level is unchanged.
  - FADE_OUT: every FADE_DIV frame_ticks, level decrements by 1. When level reaches 0 -> BLACK.
  - BLACK: level is held at 0. fade_in_req -> FADE_IN, step counter cleared.
  - FADE_IN: every FADE_DIV frame_ticks, level increments by 1. When level reaches 15 -> IDLE.
- Request handling:
  - Requests not listed for the current state are ignored and not queued, e.g. flash_req during a fade, or fade_out_req in BLACK.
  - flash_req and fade_out_req in the same IDLE cycle: flash wins and fade_out_req is dropped.
  - A request and a frame_tick in the same cycle: the request is taken and the tick is not counted.
- Effect timing: an FSM/level change is visible on rgb from the first stage-2 update after the register changes. No mid-frame re-synchronisation is applied.
- Reset mid-effect immediately returns FSM to IDLE with level=15.

Test Plan:
- NUM_LAYERS=5, all layers enabled, layer_on=5'b00110, layer1=12'h0C0, layer2=12'h00F, vid_on=1 -> after 2 clk, rgb=12'h0C0, layer_sel=1.
- Same stimulus with layer_en[1]=0 -> rgb=12'h00F, layer_sel=2. Then layer2 colour set to 12'hF0F with KEY_EN=1 -> rgb=bg_rgb, layer_sel=5.
- vid_on=0 with layers active -> rgb=0, rgb_vid_on=0, layer_sel=5, with 2-clk alignment checked on toggling.
- flash_req, then 4 frame_ticks, with pixel 12'h6BC -> rgb=12'hFFF, fx_busy=1 until the 4th tick. Afterwards rgb=12'h6BC and fx_busy=0.
- fade_out_req with FADE_DIV=2, pixel 12'h6BC -> after 2 ticks rgb=12'h5AB; after 30 ticks FSM=BLACK and rgb=12'h000. flash_req in BLACK is ignored. fade_in_req then returns rgb to 12'h6BC after 30 ticks, with fx_busy=0.
- Assert reset mid-FADE_OUT at level=7 -> next cycle FSM=IDLE, fx_busy=0, rgb=0, and after reset release the output is unfaded.

Source files
------------

// File: rtl/layer_compositor_if.sv
// Pixel-path bundle between the video timing/sprite logic and the compositor.
// master drives layer pixels and effect requests; slave returns the composited pixel.
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 5,
    parameter int COLOR_W    = 12
);
    localparam int SEL_W = $clog2(NUM_LAYERS + 1);

    logic                          vid_on;
    logic [NUM_LAYERS-1:0]         layer_on;
    logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb;
    logic [NUM_LAYERS-1:0]         layer_en;
    logic [COLOR_W-1:0]            bg_rgb;
    logic                          frame_tick;
    logic                          flash_req;
    logic                          fade_out_req;
    logic                          fade_in_req;
    logic [COLOR_W-1:0]            rgb;
    logic                          rgb_vid_on;
    logic [SEL_W-1:0]              layer_sel;
    logic                          fx_busy;

    modport master (
        output vid_on, layer_on, layer_rgb, layer_en, bg_rgb,
        output frame_tick, flash_req, fade_out_req, fade_in_req,
        input  rgb, rgb_vid_on, layer_sel, fx_busy
    );

    modport slave (
        input  vid_on, layer_on, layer_rgb, layer_en, bg_rgb,
        input  frame_tick, flash_req, fade_out_req, fade_in_req,
        output rgb, rgb_vid_on, layer_sel, fx_busy
    );
endinterface

// File: rtl/layer_compositor.sv
// Priority layer compositor with frame-synchronous flash / fade effects.
// Fixed 2-clk latency pixel-in to pixel-out; one pixel per clk, never stalls.
module layer_compositor #(
    parameter int                 NUM_LAYERS   = 5,
    parameter int                 COLOR_W      = 12,
    parameter int                 KEY_EN       = 1,
    parameter logic [COLOR_W-1:0] KEY_RGB      = 12'hF0F,
    parameter logic [COLOR_W-1:0] FLASH_RGB    = 12'hFFF,
    parameter int                 FLASH_FRAMES = 4,
    parameter int                 FADE_DIV     = 2
) (
    input logic                clk,
    input logic                reset,
    layer_compositor_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_LAYERS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLASH,
        S_FADE_OUT,
        S_BLACK,
        S_FADE_IN
    } fx_state_t;

    fx_state_t          r_state, w_state_nxt;
    logic [3:0]         r_level, w_level_nxt;
    logic [7:0]         r_frame_cnt, w_frame_nxt, w_frame_inc;
    logic [7:0]         r_step_cnt, w_step_nxt, w_step_inc;

    logic [NUM_LAYERS-1:0] w_vis;
    logic [COLOR_W-1:0]    w_win_rgb;
    logic [SEL_W-1:0]      w_win_sel;

    logic [COLOR_W-1:0] r_s1_rgb;
    logic [SEL_W-1:0]   r_s1_sel;
    logic               r_s1_vid;

    logic [COLOR_W-1:0] r_rgb;
    logic [SEL_W-1:0]   r_sel;
    logic               r_vid;

    // Subtract (15 - level) from a channel, saturating at zero.
    function automatic logic [3:0] fade_ch(input logic [3:0] c, input logic [3:0] lvl);
        logic [4:0] s;
        s = {1'b0, c} + {1'b0, lvl};
        return (s >= 5'd15) ? 4'(s - 5'd15) : 4'd0;
    endfunction

    // Descending scan so the lowest visible index overwrites and wins.
    always_comb begin
        w_vis     = '0;
        w_win_rgb = bus.bg_rgb;
        w_win_sel = SEL_W'(NUM_LAYERS);
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            w_vis[i] = bus.layer_on[i] & bus.layer_en[i] &
                       !((KEY_EN != 0) && (bus.layer_rgb[COLOR_W*i +: COLOR_W] == KEY_RGB));
            if (w_vis[i]) begin
                w_win_rgb = bus.layer_rgb[COLOR_W*i +: COLOR_W];
                w_win_sel = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_rgb <= '0;
            r_s1_sel <= SEL_W'(NUM_LAYERS);
            r_s1_vid <= 1'b0;
        end else begin
            r_s1_vid <= bus.vid_on;
            r_s1_rgb <= bus.vid_on ? w_win_rgb : '0;
            r_s1_sel <= bus.vid_on ? w_win_sel : SEL_W'(NUM_LAYERS);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb <= '0;
            r_sel <= SEL_W'(NUM_LAYERS);
            r_vid <= 1'b0;
        end else begin
            r_vid <= r_s1_vid;
            r_sel <= r_s1_sel;
            if (!r_s1_vid)
                r_rgb <= '0;
            else if (r_state == S_FLASH)
                r_rgb <= FLASH_RGB;
            else
                r_rgb <= {fade_ch(r_s1_rgb[11:8], r_level),
                          fade_ch(r_s1_rgb[7:4],  r_level),
                          fade_ch(r_s1_rgb[3:0],  r_level)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_level     <= 4'd15;
            r_frame_cnt <= '0;
            r_step_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_level     <= w_level_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_step_cnt  <= w_step_nxt;
        end
    end

    // Requests are only honoured in the states that accept them; a tick in
    // the same cycle as an accepted request is swallowed by the transition.
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_frame_nxt = r_frame_cnt;
        w_step_nxt  = r_step_cnt;
        w_frame_inc = r_frame_cnt + 8'd1;
        w_step_inc  = r_step_cnt + 8'd1;
        case (r_state)
            S_IDLE: begin
                if (bus.flash_req) begin
                    w_state_nxt = S_FLASH;
                    w_frame_nxt = '0;
                end else if (bus.fade_out_req) begin
                    w_state_nxt = S_FADE_OUT;
                    w_step_nxt  = '0;
                end
            end
            S_FLASH: begin
                if (bus.frame_tick) begin
                    if (w_frame_inc == 8'(FLASH_FRAMES)) begin
                        w_state_nxt = S_IDLE;
                        w_frame_nxt = '0;
                    end else begin
                        w_frame_nxt = w_frame_inc;
                    end
                end
            end
            S_FADE_OUT: begin
                if (bus.frame_tick) begin
                    if (w_step_inc == 8'(FADE_DIV)) begin
                        w_step_nxt  = '0;
                        w_level_nxt = r_level - 4'd1;
                        if (r_level == 4'd1)
                            w_state_nxt = S_BLACK;
                    end else begin
                        w_step_nxt = w_step_inc;
                    end
                end
            end
            S_BLACK: begin
                if (bus.fade_in_req) begin
                    w_state_nxt = S_FADE_IN;
                    w_step_nxt  = '0;
                end
            end
            S_FADE_IN: begin
                if (bus.frame_tick) begin
                    if (w_step_inc == 8'(FADE_DIV)) begin
                        w_step_nxt  = '0;
                        w_level_nxt = r_level + 4'd1;
                        if (r_level == 4'd14)
                            w_state_nxt = S_IDLE;
                    end else begin
                        w_step_nxt = w_step_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_level_nxt = 4'd15;
            end
        endcase
    end

    assign bus.rgb        = r_rgb;
    assign bus.rgb_vid_on = r_vid;
    assign bus.layer_sel  = r_sel;
    assign bus.fx_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_layer_compositor.sv
// Randomised + directed scoreboard bench for layer_compositor.
// Driver pushes expectations from a behavioural model; a negedge monitor pops and compares.
module tb_layer_compositor;
    localparam int          NL           = 5;
    localparam int          CW           = 12;
    localparam int          FLASH_FRAMES = 4;
    localparam int          FADE_DIV     = 2;
    localparam logic [11:0] KEY          = 12'hF0F;
    localparam logic [11:0] FLASH_C      = 12'hFFF;

    localparam int M_IDLE = 0, M_FLASH = 1, M_FADE_OUT = 2, M_BLACK = 3, M_FADE_IN = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    layer_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) bus ();

    layer_compositor #(
        .NUM_LAYERS(NL), .COLOR_W(CW), .KEY_EN(1), .KEY_RGB(KEY),
        .FLASH_RGB(FLASH_C), .FLASH_FRAMES(FLASH_FRAMES), .FADE_DIV(FADE_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic        vid;
        logic [2:0]  sel;
    } pix_exp_t;

    typedef struct {
        int   due;
        logic busy;
    } busy_exp_t;

    pix_exp_t  q_pix[$];
    busy_exp_t q_busy[$];

    int m_mode  = M_IDLE;
    int m_cnt   = 0;
    int m_level = 15;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_cnt   = 0;
        m_level = 15;
    endtask

    // Effect rules: requests only where accepted; an accepted request eats a same-cycle tick.
    task automatic model_fx(input logic tick, input logic fl, input logic fo, input logic fi);
        case (m_mode)
            M_IDLE: begin
                if (fl) begin m_mode = M_FLASH; m_cnt = 0; end
                else if (fo) begin m_mode = M_FADE_OUT; m_cnt = 0; end
            end
            M_FLASH: if (tick) begin
                m_cnt++;
                if (m_cnt == FLASH_FRAMES) begin m_mode = M_IDLE; m_cnt = 0; end
            end
            M_FADE_OUT: if (tick) begin
                m_cnt++;
                if (m_cnt == FADE_DIV) begin
                    m_cnt = 0;
                    m_level--;
                    if (m_level == 0) m_mode = M_BLACK;
                end
            end
            M_BLACK: if (fi) begin m_mode = M_FADE_IN; m_cnt = 0; end
            M_FADE_IN: if (tick) begin
                m_cnt++;
                if (m_cnt == FADE_DIV) begin
                    m_cnt = 0;
                    m_level++;
                    if (m_level == 15) m_mode = M_IDLE;
                end
            end
            default: model_reset();
        endcase
    endtask

    task automatic drive(input logic vid, input logic [NL-1:0] on, input logic [NL-1:0] en,
                         input logic [NL*CW-1:0] lrgb, input logic [11:0] bg,
                         input logic tick, input logic fl, input logic fo, input logic fi);
        pix_exp_t    pe;
        busy_exp_t   be;
        logic [11:0] c;
        logic [2:0]  s;
        int          ch;
        bus.vid_on       = vid;
        bus.layer_on     = on;
        bus.layer_en     = en;
        bus.layer_rgb    = lrgb;
        bus.bg_rgb       = bg;
        bus.frame_tick   = tick;
        bus.flash_req    = fl;
        bus.fade_out_req = fo;
        bus.fade_in_req  = fi;
        model_fx(tick, fl, fo, fi);
        c = bg;
        s = 3'(NL);
        for (int i = 0; i < NL; i++) begin
            if (on[i] && en[i] && (lrgb[CW*i +: CW] != KEY)) begin
                c = lrgb[CW*i +: CW];
                s = 3'(i);
                break;
            end
        end
        if (!vid) begin
            c = 12'h000;
            s = 3'(NL);
        end else if (m_mode == M_FLASH) begin
            c = FLASH_C;
        end else begin
            for (int k = 0; k < 3; k++) begin
                ch = int'(c[4*k +: 4]) - (15 - m_level);
                if (ch < 0) ch = 0;
                c[4*k +: 4] = 4'(ch);
            end
        end
        pe.due = cyc + 2; pe.rgb = c; pe.vid = vid; pe.sel = s;
        be.due = cyc + 1; be.busy = (m_mode != M_IDLE);
        q_pix.push_back(pe);
        q_busy.push_back(be);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        pix_exp_t  pe;
        busy_exp_t be;
        if (!reset) begin
            while (q_pix.size() > 0 && q_pix[0].due <= cyc) begin
                pe = q_pix.pop_front();
                check("rgb", 32'(bus.rgb), 32'(pe.rgb));
                check("rgb_vid_on", 32'(bus.rgb_vid_on), 32'(pe.vid));
                check("layer_sel", 32'(bus.layer_sel), 32'(pe.sel));
            end
            while (q_busy.size() > 0 && q_busy[0].due <= cyc) begin
                be = q_busy.pop_front();
                check("fx_busy", 32'(bus.fx_busy), 32'(be.busy));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_reqs();
        bus.frame_tick = 1'b0; bus.flash_req = 1'b0;
        bus.fade_out_req = 1'b0; bus.fade_in_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"}, 32'(bus.rgb), 32'h0);
        check({tag, "_vid"}, 32'(bus.rgb_vid_on), 32'h0);
        check({tag, "_sel"}, 32'(bus.layer_sel), 32'(NL));
        check({tag, "_busy"}, 32'(bus.fx_busy), 32'h0);
    endtask

    initial begin : stim
        logic [NL*CW-1:0] lr;
        logic [NL*CW-1:0] px;
        logic [NL-1:0]    en, on;
        logic [11:0]      bg;
        bus.vid_on = 1'b0; bus.layer_on = '0; bus.layer_en = '0;
        bus.layer_rgb = '0; bus.bg_rgb = '0;
        idle_reqs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        model_reset();

        // Priority and enable masking
        bg = 12'h123;
        lr = {12'h000, 12'h000, 12'h00F, 12'h0C0, 12'h000};
        repeat (3) drive(1, 5'b00110, 5'b11111, lr, bg, 0, 0, 0, 0);
        repeat (2) drive(1, 5'b00110, 5'b11101, lr, bg, 0, 0, 0, 0);
        // Colour key makes layer 2 transparent -> background
        lr = {12'h000, 12'h000, KEY, 12'h0C0, 12'h000};
        repeat (2) drive(1, 5'b00110, 5'b11101, lr, bg, 0, 0, 0, 0);

        // Blanking alignment on vid_on toggles
        lr = {12'h000, 12'h000, 12'h00F, 12'h0C0, 12'h000};
        drive(1, 5'b00110, 5'b11111, lr, bg, 0, 0, 0, 0);
        drive(0, 5'b00110, 5'b11111, lr, bg, 0, 0, 0, 0);
        drive(1, 5'b00110, 5'b11111, lr, bg, 0, 0, 0, 0);
        drive(0, 5'b00110, 5'b11111, lr, bg, 0, 0, 0, 0);
        drive(0, 5'b00110, 5'b11111, lr, bg, 0, 0, 0, 0);
        drive(1, 5'b00110, 5'b11111, lr, bg, 0, 0, 0, 0);

        // Flash over pixel 6BC for FLASH_FRAMES ticks
        px = {48'h0, 12'h6BC};
        drive(1, 5'b00001, 5'b11111, px, bg, 0, 1, 0, 0);
        for (int t = 0; t < FLASH_FRAMES; t++) begin
            drive(1, 5'b00001, 5'b11111, px, bg, 1, 0, 0, 0);
            repeat (2) drive(1, 5'b00001, 5'b11111, px, bg, 0, 0, 0, 0);
        end

        // Fade to black, ignored requests in BLACK, fade back in
        drive(1, 5'b00001, 5'b11111, px, bg, 0, 0, 1, 0);
        for (int t = 0; t < 30; t++) begin
            drive(1, 5'b00001, 5'b11111, px, bg, 1, 0, 0, 0);
            drive(1, 5'b00001, 5'b11111, px, bg, 0, 0, 0, 0);
        end
        drive(1, 5'b00001, 5'b11111, px, bg, 0, 1, 0, 0);
        drive(1, 5'b00001, 5'b11111, px, bg, 1, 0, 1, 0);
        repeat (2) drive(1, 5'b00001, 5'b11111, px, bg, 0, 0, 0, 0);
        drive(1, 5'b00001, 5'b11111, px, bg, 0, 0, 0, 1);
        for (int t = 0; t < 30; t++) begin
            drive(1, 5'b00001, 5'b11111, px, bg, 1, 0, 0, 0);
            drive(1, 5'b00001, 5'b11111, px, bg, 0, 0, 0, 0);
        end
        repeat (3) drive(1, 5'b00001, 5'b11111, px, bg, 0, 0, 0, 0);

        // Reset in the middle of a fade-out at level 7
        drive(1, 5'b00001, 5'b11111, px, bg, 0, 0, 1, 0);
        for (int t = 0; t < 200 && m_level != 7; t++)
            drive(1, 5'b00001, 5'b11111, px, bg, 1, 0, 0, 0);
        check("level_reached_7", 32'(m_level), 32'd7);
        repeat (2) drive(1, 5'b00001, 5'b11111, px, bg, 0, 0, 0, 0);
        idle_reqs();
        reset = 1'b1;
        q_pix.delete();
        q_busy.delete();
        @(negedge clk);
        check_reset_outputs("midfx_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (4) drive(1, 5'b00001, 5'b11111, px, bg, 0, 0, 0, 0);

        // Randomised traffic including overlapping requests and ticks
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NL; i++)
                lr[CW*i +: CW] = ($urandom_range(0, 5) == 0) ? KEY : 12'($urandom);
            on = NL'($urandom);
            en = NL'($urandom) | NL'($urandom);
            bg = 12'($urandom);
            drive($urandom_range(0, 7) != 0, on, en, lr, bg,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0);
        end

        idle_reqs();
        repeat (4) drive(0, '0, '0, '0, '0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("drain_pix", 32'(q_pix.size()), 32'd0);
        check("drain_busy", 32'(q_busy.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
